// File: rtl/prog_mem.sv
// 16 x 8 program store with a byte-serial loader and a held-off CPU reset.
// The CPU reads combinationally at any time. A download resets the CPU,
// streams up to 16 bytes in, then holds the CPU in reset for RESET_HOLD
// cycles before releasing it.
module prog_mem #(
  parameter int unsigned RESET_HOLD     = 2,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic [3:0] addr,
  output logic [7:0] data,
  input  logic       load_start,
  input  logic       ld_valid,
  input  logic [7:0] ld_data,
  output logic       ld_ready,
  input  logic       ld_abort,
  output logic       cpu_n_reset,
  output logic       loading,
  output logic       load_done
);

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned HW    = 4;
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  localparam logic [HW-1:0] HOLD_INIT = HW'(RESET_HOLD);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LOAD    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  logic [DW-1:0] mem [DEPTH];

  state_t        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          full_q, full_d;
  logic          wr_en;
  logic          cpu_n_reset_d, ld_ready_d, loading_d, load_done_d;

  // Asynchronous read: a same-cycle write is only visible after the edge.
  assign data = mem[addr];

  // Next-state, pointer, hold counter and registered-output decode.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    ptr_d   = ptr_q;
    full_d  = full_q;
    wr_en   = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (load_start) begin
          state_d = ST_LOAD;
          ptr_d   = '0;
          full_d  = 1'b0;
        end
      end
      ST_LOAD: begin
        if (ld_abort) begin
          state_d = ST_RELEASE;
          hold_d  = HOLD_INIT;
          full_d  = 1'b0;
        end else if (ld_valid && ld_ready) begin
          wr_en = 1'b1;
          if (ptr_q == LAST_PTR) begin
            // Final byte: pointer parks at 15 rather than wrapping.
            state_d = ST_RELEASE;
            hold_d  = HOLD_INIT;
            full_d  = 1'b1;
          end else begin
            ptr_d = ptr_q + AW'(1);
          end
        end
      end
      ST_RELEASE: begin
        hold_d = hold_q - HW'(1);
        if (hold_q <= HW'(1)) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RELEASE;
        hold_d  = HOLD_INIT;
      end
    endcase

    cpu_n_reset_d = (state_d == ST_RUN);
    ld_ready_d    = (state_d == ST_LOAD);
    loading_d     = (state_d == ST_LOAD);
    load_done_d   = (state_q == ST_RELEASE) && (state_d == ST_RUN) && full_q;
  end

  // State, counters and output flops; reset parks in RELEASE to hold the CPU.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q     <= ST_RELEASE;
      hold_q      <= HOLD_INIT;
      ptr_q       <= '0;
      full_q      <= 1'b0;
      cpu_n_reset <= 1'b0;
      ld_ready    <= 1'b0;
      loading     <= 1'b0;
      load_done   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      ptr_q       <= ptr_d;
      full_q      <= full_d;
      cpu_n_reset <= cpu_n_reset_d;
      ld_ready    <= ld_ready_d;
      loading     <= loading_d;
      load_done   <= load_done_d;
    end
  end

  // Storage: optional clear on reset, loader writes otherwise.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      if (CLEAR_ON_RESET != 0) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          mem[i] <= '0;
        end
      end
    end else if (wr_en) begin
      mem[ptr_q] <= ld_data;
    end
  end

endmodule

// File: tb/tb_prog_mem.sv
// Self-checking bench for prog_mem: randomized loader traffic against an
// image-level model of the program store and the release timing.
module tb_prog_mem;

  localparam int HOLD = 2;

  logic       clk = 1'b0;
  logic       n_reset;
  logic [3:0] addr;
  logic [7:0] data;
  logic       load_start;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_ready;
  logic       ld_abort;
  logic       cpu_n_reset;
  logic       loading;
  logic       load_done;

  logic [7:0] exp_mem [16];
  logic [7:0] src [16];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  prog_mem #(.RESET_HOLD(HOLD), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .n_reset(n_reset), .addr(addr), .data(data),
    .load_start(load_start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .ld_abort(ld_abort), .cpu_n_reset(cpu_n_reset),
    .loading(loading), .load_done(load_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Generic download: pattern 0 back-to-back, 1 toggling, 2 random gaps.
  // abort_after < 0 means no abort.
  task automatic run_load(input int pattern, input int abort_after, input string tag);
    int   acc = 0;
    bit   aborted = 1'b0;
    logic v;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    total++;
    if ({loading, ld_ready, cpu_n_reset} !== 3'b110) begin
      bad++;
      $display("FAIL %s_enter got=%b want=110", tag, {loading, ld_ready, cpu_n_reset});
    end
    for (int cyc = 0; cyc < 200 && acc < 16 && !aborted; cyc++) begin
      if (acc == abort_after) begin
        ld_abort = 1'b1;
        ld_valid = 1'b1;
        ld_data  = 8'hEE;
        tick();
        ld_abort = 1'b0;
        aborted  = 1'b1;
      end else begin
        case (pattern)
          0:       v = 1'b1;
          1:       v = 1'((cyc % 2) == 0);
          default: v = 1'($urandom_range(0, 1));
        endcase
        ld_valid = v;
        ld_data  = src[acc];
        addr     = 4'(acc);
        #1;
        total++;
        if (data !== exp_mem[acc]) begin
          bad++;
          $display("FAIL %s_old_read addr=%0d got=%h want=%h", tag, acc, data, exp_mem[acc]);
        end
        tick();
        if (v) begin
          exp_mem[acc] = src[acc];
          total++;
          if (data !== src[acc]) begin
            bad++;
            $display("FAIL %s_new_read addr=%0d got=%h want=%h", tag, acc, data, src[acc]);
          end
          acc++;
        end
        total++;
        if (ld_ready !== 1'(acc < 16)) begin
          bad++;
          $display("FAIL %s_ready acc=%0d got=%b want=%b", tag, acc, ld_ready, 1'(acc < 16));
        end
      end
    end
    total++;
    if (!(acc == 16 || aborted)) begin
      bad++;
      $display("FAIL %s_timeout accepted=%0d want=16", tag, acc);
    end
    // A 17th byte offered during release must be dropped.
    ld_valid = 1'b1;
    ld_data  = 8'hFF;
    total++;
    if ({loading, ld_ready, cpu_n_reset} !== 3'b000) begin
      bad++;
      $display("FAIL %s_release got=%b want=000", tag, {loading, ld_ready, cpu_n_reset});
    end
    for (int k = 1; k <= HOLD; k++) begin
      tick();
      total++;
      if (cpu_n_reset !== 1'(k == HOLD)) begin
        bad++;
        $display("FAIL %s_cpu_rst k=%0d got=%b want=%b", tag, k, cpu_n_reset, 1'(k == HOLD));
      end
      total++;
      if (load_done !== 1'(k == HOLD && !aborted)) begin
        bad++;
        $display("FAIL %s_done k=%0d got=%b want=%b", tag, k, load_done, 1'(k == HOLD && !aborted));
      end
    end
    ld_valid = 1'b0;
    tick();
    total++;
    if (load_done !== 1'b0) begin
      bad++;
      $display("FAIL %s_done_pulse got=%b want=0", tag, load_done);
    end
    for (int i = 0; i < 16; i++) begin
      addr = 4'(i);
      #1;
      total++;
      if (data !== exp_mem[i]) begin
        bad++;
        $display("FAIL %s_image addr=%0d got=%h want=%h", tag, i, data, exp_mem[i]);
      end
    end
  endtask

  task automatic test_reset();
    n_reset = 1'b0; load_start = 1'b0; ld_valid = 1'b0; ld_abort = 1'b0;
    ld_data = 8'h00; addr = 4'd0;
    tick();
    tick();
    total++;
    if ({cpu_n_reset, ld_ready, loading, load_done} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=0000", {cpu_n_reset, ld_ready, loading, load_done});
    end
    for (int i = 0; i < 16; i++) begin
      exp_mem[i] = 8'h00;
      addr = 4'(i);
      #1;
      total++;
      if (data !== 8'h00) begin
        bad++;
        $display("FAIL reset_clear addr=%0d got=%h want=00", i, data);
      end
    end
    @(negedge clk);
    n_reset = 1'b1;
    for (int k = 1; k <= HOLD; k++) begin
      tick();
      total++;
      if (cpu_n_reset !== 1'(k == HOLD) || load_done !== 1'b0) begin
        bad++;
        $display("FAIL reset_release k=%0d got=%b%b want=%b0", k, cpu_n_reset, load_done, 1'(k == HOLD));
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) src[i] = 8'hB0 + 8'(i);
    run_load(0, -1, "b2b");
  endtask

  task automatic test_toggle();
    for (int i = 0; i < 16; i++) src[i] = 8'($urandom);
    run_load(1, -1, "toggle");
  endtask

  task automatic test_random_gaps();
    for (int i = 0; i < 16; i++) src[i] = 8'($urandom);
    run_load(2, -1, "gaps");
  endtask

  task automatic test_abort();
    for (int i = 0; i < 16; i++) src[i] = 8'hB0 + 8'(i);
    run_load(0, -1, "abort_first");
    for (int i = 0; i < 16; i++) src[i] = 8'h3C;
    run_load(0, 5, "abort");
  endtask

  task automatic test_run_ignore();
    for (int c = 0; c < 20; c++) begin
      ld_valid = 1'b1;
      ld_data  = 8'($urandom);
      ld_abort = 1'($urandom_range(0, 1));
      tick();
      total++;
      if ({ld_ready, loading, cpu_n_reset} !== 3'b001) begin
        bad++;
        $display("FAIL run_ignore c=%0d got=%b want=001", c, {ld_ready, loading, cpu_n_reset});
      end
    end
    ld_valid = 1'b0;
    ld_abort = 1'b0;
    for (int i = 0; i < 16; i++) begin
      addr = 4'(i);
      #1;
      total++;
      if (data !== exp_mem[i]) begin
        bad++;
        $display("FAIL run_ignore_image addr=%0d got=%h want=%h", i, data, exp_mem[i]);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      ld_valid = 1'b1;
      ld_data  = 8'($urandom);
      tick();
    end
    n_reset  = 1'b0;
    ld_data  = 8'h77;
    tick();
    ld_valid = 1'b0;
    total++;
    if ({loading, ld_ready, cpu_n_reset, load_done} !== 4'b0000) begin
      bad++;
      $display("FAIL midrst_outputs got=%b want=0000", {loading, ld_ready, cpu_n_reset, load_done});
    end
    for (int i = 0; i < 16; i++) begin
      exp_mem[i] = 8'h00;
      addr = 4'(i);
      #1;
      total++;
      if (data !== 8'h00) begin
        bad++;
        $display("FAIL midrst_clear addr=%0d got=%h want=00", i, data);
      end
    end
    @(negedge clk);
    n_reset = 1'b1;
    for (int k = 1; k <= HOLD; k++) begin
      load_start = 1'(k == 1);
      tick();
      load_start = 1'b0;
      total++;
      if ({loading, cpu_n_reset, load_done} !== {1'b0, 1'(k == HOLD), 1'b0}) begin
        bad++;
        $display("FAIL midrst_release k=%0d got=%b want=0%b0", k, {loading, cpu_n_reset, load_done}, 1'(k == HOLD));
      end
    end
    tick();
    total++;
    if ({loading, cpu_n_reset} !== 2'b01) begin
      bad++;
      $display("FAIL midrst_run got=%b want=01", {loading, cpu_n_reset});
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_toggle();
    test_random_gaps();
    test_abort();
    test_run_ignore();
    test_reset_mid_load();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
